// File: rtl/mem_uart_tx.sv
// mem_uart_tx: memory-mapped 8N1 UART transmitter on the nanorv32 native bus.
//
// Writes to DATA are queued in a small byte FIFO. The transmit FSM drains the
// FIFO onto txd using a programmable clocks-per-bit divider.
//
// Register window (16 bytes at BASE_ADDR, offset = mem_addr[3:2]):
//   0 DATA   W: push wdata[7:0]           R: 0
//   1 STATUS R: [0] busy [1] empty [2] full [3] overflow [15:8] level
//            W: wstrb[0] && wdata[3] clears overflow
//   2 DIV    R/W: clocks per bit, byte-strobed, 0 is stored as 1
//   3 -      R: 0, writes ignored
//
// Ports:
//   clk        clock
//   resetn     synchronous active-low reset
//   mem_valid  bus request valid
//   mem_addr   byte address
//   mem_wdata  write data
//   mem_wstrb  byte write strobes, 0 = read
//   mem_ready  one-cycle transfer-complete pulse
//   mem_rdata  read data, zero whenever mem_ready is low
//   txd        serial output, idle high
//
// TX FSM states:
//   state   | meaning
//   S_IDLE  | line idle, waiting for the FIFO to become non-empty
//   S_START | start bit (low) for frame_div cycles
//   S_DATA  | eight data bits, LSB first, frame_div cycles each
//   S_STOP  | stop bit (high) for frame_div cycles
module mem_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        txd
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state;
    logic            r_ready;
    logic [31:0]     r_rdata;
    logic            r_txd;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic [15:0]     r_cyc_cnt;
    logic [15:0]     r_frame_div;
    logic [15:0]     r_div;
    logic            r_ovf;
    logic [7:0]      r_fifo [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;

    logic            w_sel;
    logic            w_req;
    logic            w_wr;
    logic [1:0]      w_off;
    logic            w_empty;
    logic            w_full;
    logic            w_push_req;
    logic            w_push;
    logic            w_ovf_evt;
    logic            w_ovf_clr;
    logic            w_pop;
    logic            w_div_lo_we;
    logic            w_div_hi_we;
    logic [15:0]     w_div_raw;
    logic [15:0]     w_div_next;
    logic [31:0]     w_status;
    logic [31:0]     w_rd_val;
    logic            w_unused;

    assign w_sel = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    // mem_ready high blocks a second accept, giving one transfer per two cycles
    assign w_req = w_sel && !r_ready;
    assign w_wr  = w_req && (mem_wstrb != 4'b0000);
    assign w_off = mem_addr[3:2];

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == (AW+1)'(FIFO_DEPTH));

    // Full is judged on the registered level: a same-cycle pop does not make room
    assign w_push_req = w_wr && (w_off == 2'd0) && mem_wstrb[0];
    assign w_push     = w_push_req && !w_full;
    assign w_ovf_evt  = w_push_req && w_full;
    assign w_ovf_clr  = w_wr && (w_off == 2'd1) && mem_wstrb[0] && mem_wdata[3];

    assign w_div_lo_we = w_wr && (w_off == 2'd2) && mem_wstrb[0];
    assign w_div_hi_we = w_wr && (w_off == 2'd2) && mem_wstrb[1];
    assign w_div_raw   = {w_div_hi_we ? mem_wdata[15:8] : r_div[15:8],
                          w_div_lo_we ? mem_wdata[7:0]  : r_div[7:0]};
    assign w_div_next  = (w_div_raw == 16'd0) ? 16'd1 : w_div_raw;

    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && (r_cyc_cnt == '0)));

    assign w_status = {16'h0, 8'(r_level), 4'h0, r_ovf, w_full, w_empty, r_state != S_IDLE};

    always_comb begin
        w_rd_val = 32'h0;
        case (w_off)
            2'd1:    w_rd_val = w_status;
            2'd2:    w_rd_val = {16'h0, r_div};
            default: w_rd_val = 32'h0;
        endcase
    end

    assign w_unused = &{1'b0, mem_wdata[31:16], mem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
            r_div   <= DEFAULT_DIV;
            r_ovf   <= 1'b0;
        end else begin
            r_ready <= w_req;
            r_rdata <= w_req ? w_rd_val : 32'h0;
            if (w_div_lo_we || w_div_hi_we)
                r_div <= w_div_next;
            // a same-cycle overflow wins over the clear
            if (w_ovf_evt)
                r_ovf <= 1'b1;
            else if (w_ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_txd       <= 1'b1;
            r_shift     <= 8'h0;
            r_bit_cnt   <= 3'd0;
            r_cyc_cnt   <= 16'd0;
            r_frame_div <= DEFAULT_DIV;
        end else begin
            // txd follows the state one cycle later from a flop, so it never glitches
            case (r_state)
                S_START: r_txd <= 1'b0;
                S_DATA:  r_txd <= r_shift[0];
                default: r_txd <= 1'b1;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift     <= r_fifo[r_rd_ptr];
                        r_frame_div <= r_div;
                        r_cyc_cnt   <= r_div - 16'd1;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    if (r_cyc_cnt == '0) begin
                        r_cyc_cnt <= r_frame_div - 16'd1;
                        r_bit_cnt <= 3'd7;
                        r_state   <= S_DATA;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_cyc_cnt == '0) begin
                        r_cyc_cnt <= r_frame_div - 16'd1;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == 3'd0)
                            r_state <= S_STOP;
                        else
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (r_cyc_cnt == '0) begin
                        // chain straight into the next frame with no idle gap
                        if (w_pop) begin
                            r_shift     <= r_fifo[r_rd_ptr];
                            r_frame_div <= r_div;
                            r_cyc_cnt   <= r_div - 16'd1;
                            r_state     <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt - 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign txd       = r_txd;

endmodule
